// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Sequencing and hazard control for a 5-stage pipeline: warm-up,
//            load-use stalls, taken-branch flushes, halt/drain/resume, and
//            saturating debug event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_mem_read,
  input  logic [4:0]       exe_rt,
  input  logic             exe_branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             clr_if_id,
  output logic             clr_id_exe,
  output logic             clr_exe_mem,
  output logic             clr_mem_wb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int C_MAX_WAIT = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
  localparam int C_WAIT_W   = (C_MAX_WAIT > 1) ? $clog2(C_MAX_WAIT) : 1;

  localparam logic [C_WAIT_W-1:0] C_INIT_LAST  = C_WAIT_W'(INIT_CYCLES - 1);
  localparam logic [C_WAIT_W-1:0] C_DRAIN_LAST = C_WAIT_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [C_WAIT_W-1:0] r_wait;
  logic [C_WAIT_W-1:0] w_next_wait;
  logic                w_load_use;
  logic                w_stall_evt;
  logic                w_flush_evt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // Register 0 is hardwired zero, so a load targeting it can never create a hazard.
  assign w_load_use = exe_mem_read && (exe_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == exe_rt)) ||
                       (id_uses_rt && (id_rt == exe_rt)));

  assign w_flush_evt = (r_state == S_RUN) && exe_branch_taken;
  assign w_stall_evt = (r_state == S_RUN) && w_load_use && !exe_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_wait  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_next_wait;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait;
    case (r_state)
      S_INIT: begin
        if (r_wait == C_INIT_LAST) begin
          w_next_state = S_RUN;
          w_next_wait  = '0;
        end else begin
          w_next_wait = r_wait + C_WAIT_W'(1);
        end
      end
      S_RUN: begin
        if (halt_req) begin
          w_next_state = S_DRAIN;
          w_next_wait  = '0;
        end
      end
      S_DRAIN: begin
        if (r_wait == C_DRAIN_LAST) begin
          w_next_state = S_HALTED;
          w_next_wait  = '0;
        end else begin
          w_next_wait = r_wait + C_WAIT_W'(1);
        end
      end
      S_HALTED: begin
        if (resume) begin
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = S_INIT;
        w_next_wait  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    clr_if_id   = 1'b0;
    clr_id_exe  = 1'b0;
    clr_exe_mem = 1'b0;
    clr_mem_wb  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_INIT: begin
        clr_if_id   = 1'b1;
        clr_id_exe  = 1'b1;
        clr_exe_mem = 1'b1;
        clr_mem_wb  = 1'b1;
      end
      S_RUN: begin
        // A taken branch redirects fetch, which makes any pending load-use stall moot.
        if (exe_branch_taken) begin
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          clr_if_id  = 1'b1;
          clr_id_exe = 1'b1;
        end else if (w_load_use) begin
          clr_id_exe = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      S_DRAIN: begin
        clr_id_exe = 1'b1;
      end
      S_HALTED: begin
        clr_id_exe = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        clr_if_id   = 1'b1;
        clr_id_exe  = 1'b1;
        clr_exe_mem = 1'b1;
        clr_mem_wb  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Scoreboard bench for pipeline_hazard_ctrl (default and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES  = 4;
  localparam int DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, exe_rt = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, exe_mem_read = 1'b0;
  logic       exe_branch_taken = 1'b0, halt_req = 1'b0, resume = 1'b0;

  logic        pc_en, if_id_en, clr_if_id, clr_id_exe, clr_exe_mem, clr_mem_wb, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_en, s_if_id_en, s_clr_if_id, s_clr_id_exe, s_clr_exe_mem, s_clr_mem_wb, s_halted;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .exe_mem_read(exe_mem_read),
    .exe_rt(exe_rt), .exe_branch_taken(exe_branch_taken), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .clr_if_id(clr_if_id), .clr_id_exe(clr_id_exe),
    .clr_exe_mem(clr_exe_mem), .clr_mem_wb(clr_mem_wb), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .exe_mem_read(exe_mem_read),
    .exe_rt(exe_rt), .exe_branch_taken(exe_branch_taken), .halt_req(halt_req), .resume(resume),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .clr_if_id(s_clr_if_id), .clr_id_exe(s_clr_id_exe),
    .clr_exe_mem(s_clr_exe_mem), .clr_mem_wb(s_clr_mem_wb), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  typedef struct packed {
    logic [6:0]  ctl;   // {pc_en, if_id_en, clr_if_id, clr_id_exe, clr_exe_mem, clr_mem_wb, halted}
    logic [15:0] stall;
    logic [15:0] flush;
    logic [1:0]  stall2;
    logic [1:0]  flush2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a phase plus a countdown of cycles left in it, and raw event tallies.
  typedef enum int {PH_WARMUP, PH_EXEC, PH_DRAINING, PH_STOPPED} phase_t;
  phase_t phase = PH_WARMUP;
  int     left = INIT_CYCLES;
  int     n_stalls = 0;
  int     n_flushes = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic tick();
    exp_t e;
    bit   lu;
    lu = exe_mem_read && (exe_rt != 0) &&
         ((id_uses_rs && id_rs == exe_rt) || (id_uses_rt && id_rt == exe_rt));
    case (phase)
      PH_WARMUP:   e.ctl = 7'b0011110;
      PH_EXEC:     e.ctl = exe_branch_taken ? 7'b1111000 : (lu ? 7'b0001000 : 7'b1100000);
      PH_DRAINING: e.ctl = 7'b0001000;
      default:     e.ctl = 7'b0001001;
    endcase
    e.stall  = 16'(sat(n_stalls, 65535));
    e.flush  = 16'(sat(n_flushes, 65535));
    e.stall2 = 2'(sat(n_stalls, 3));
    e.flush2 = 2'(sat(n_flushes, 3));
    if (!reset) exp_q.push_back(e);

    if (reset) begin
      phase = PH_WARMUP; left = INIT_CYCLES; n_stalls = 0; n_flushes = 0;
    end else begin
      case (phase)
        PH_WARMUP: begin
          left--;
          if (left == 0) phase = PH_EXEC;
        end
        PH_EXEC: begin
          if (exe_branch_taken) n_flushes++;
          else if (lu) n_stalls++;
          if (halt_req) begin phase = PH_DRAINING; left = DRAIN_CYCLES; end
        end
        PH_DRAINING: begin
          left--;
          if (left == 0) phase = PH_STOPPED;
        end
        default: if (resume) phase = PH_EXEC;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; id_rs = '0; id_rt = '0; exe_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; exe_mem_read = 1'b0;
    exe_branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rt);
    exe_mem_read = 1'b1; exe_rt = rt; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  // Monitor: every unreset cycle has one expected entry, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act, act2;
      e    = exp_q.pop_front();
      act  = {pc_en, if_id_en, clr_if_id, clr_id_exe, clr_exe_mem, clr_mem_wb, halted};
      act2 = {s_pc_en, s_if_id_en, s_clr_if_id, s_clr_id_exe, s_clr_exe_mem, s_clr_mem_wb, s_halted};
      total++;
      if (act !== e.ctl) begin
        bad++; $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
      end
      total++;
      if (act2 !== e.ctl) begin
        bad++; $display("FAIL ctl_small t=%0t got=%b want=%b", $time, act2, e.ctl);
      end
      total++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        bad++; $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        $time, stall_cnt, flush_cnt, e.stall, e.flush);
      end
      total++;
      if (s_stall_cnt !== e.stall2 || s_flush_cnt !== e.flush2) begin
        bad++; $display("FAIL counters_small t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        $time, s_stall_cnt, s_flush_cnt, e.stall2, e.flush2);
      end
    end
  end

  initial begin
    #1;
    idle(); reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (INIT_CYCLES + 2) tick();
    set_lu(5'd8); tick();
    idle(); tick();
    set_lu(5'd0); tick();
    idle(); set_lu(5'd8); exe_branch_taken = 1'b1; tick();
    idle(); halt_req = 1'b1; tick();
    idle(); repeat (DRAIN_CYCLES) tick();
    halt_req = 1'b1; tick(); tick();
    idle(); resume = 1'b1; tick();
    idle(); tick();
    exe_branch_taken = 1'b1; halt_req = 1'b1; tick();
    idle(); tick();
    reset = 1'b1; tick();
    idle(); repeat (INIT_CYCLES + 1) tick();
    repeat (5) begin set_lu(5'd8); tick(); idle(); tick(); end
    repeat (4) begin exe_branch_taken = 1'b1; tick(); idle(); end

    for (int i = 0; i < 2000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      exe_rt           = 5'($urandom_range(0, 3));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      exe_mem_read     = 1'($urandom_range(0, 1));
      exe_branch_taken = ($urandom_range(0, 5) == 0);
      halt_req         = ($urandom_range(0, 24) == 0);
      resume           = ($urandom_range(0, 5) == 0);
      tick();
    end
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing and hazard controller for the 5-stage pipelined CPU (IF, ID, EXE, MEM, WB). After reset it holds every pipeline register cleared for a fixed warm-up window, then generates per-cycle PC/IF_ID write enables and per-register clears. These cover load-use stalls, taken-branch flushes and a halt/drain/resume sequence. It also keeps saturating stall and flush event counters for debug.

Parameters:
INIT_CYCLES, 4, cycles all pipeline registers are held cleared after reset (must be ≥1)
DRAIN_CYCLES, 3, bubble cycles inserted after a halt request before HALTED (must be ≥1)
CNT_W, 16, width of the event counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
exe_mem_read  in  1  instruction in EXE is a load
exe_rt  in  5  load destination register in EXE
exe_branch_taken  in  1  branch/jump resolved taken in EXE this cycle
halt_req  in  1  request to stop fetching and drain the pipeline
resume  in  1  leave HALTED
pc_en  out  1  PC write enable
if_id_en  out  1  IF_ID write enable
clr_if_id, clr_id_exe, clr_exe_mem, clr_mem_wb  out  1 each  synchronous clear of that pipeline register
halted  out  1  high in HALTED
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- States: INIT, RUN, DRAIN, HALTED. State and counters are registered; enables and clears are decoded combinationally from the state and the current inputs.
- Reset (any cycle, including mid-DRAIN or mid-stall):
  - next state INIT, init counter = 0, stall_cnt = 0, flush_cnt = 0.
  - reset overrides all other inputs.
- INIT:
  - pc_en = 0, if_id_en = 0, all four clr_* = 1, halted = 0.
  - Stays INIT_CYCLES cycles, then RUN. The first fetch (pc_en = 1) occurs in cycle INIT_CYCLES+1 after reset deasserts.
- RUN defaults: pc_en = 1, if_id_en = 1, all clr_* = 0.
- Load-use hazard, lu = exe_mem_read & (exe_rt != 0) & ((id_uses_rs & id_rs == exe_rt) | (id_uses_rt & id_rt == exe_rt)):
  - pc_en = 0, if_id_en = 0, clr_id_exe = 1 (one bubble).
  - stall_cnt += 1.
- Taken branch (exe_branch_taken):
  - pc_en = 1 (target loaded), if_id_en = 1, clr_if_id = 1, clr_id_exe = 1.
  - flush_cnt += 1.
  - Branch has priority over lu in the same cycle; stall_cnt is not incremented.
- Halt request:
  - halt_req in RUN → DRAIN on the next edge; the current cycle is still processed as RUN, including stall/flush.
  - Branch and halt_req together: the flush is applied, then DRAIN.
- DRAIN:
  - pc_en = 0, if_id_en = 0, clr_id_exe = 1 each cycle.
  - Lasts DRAIN_CYCLES cycles, then HALTED.
  - Ignores hazards, branch, halt_req and resume.
- HALTED:
  - pc_en = 0, if_id_en = 0, clr_id_exe = 1, halted = 1.
  - resume → RUN next edge. halt_req is ignored; resume wins if both are high.
- Counters:
  - Saturate at all-ones (no wrap).
  - Increment only in RUN.
- Register 0 never causes a stall; exe_rt = 0 with a load gives no stall.

Test Plan:
- Reset held 2 cycles, then released → clr_* all 1 and pc_en = 0 for exactly 4 cycles; pc_en = 1 on cycle 5; counters read 0.
- RUN, exe_mem_read = 1, exe_rt = 8, id_rs = 8, id_uses_rs = 1 for one cycle → that cycle pc_en = 0, if_id_en = 0, clr_id_exe = 1; stall_cnt = 1. Repeat with exe_rt = 0 → no stall, stall_cnt stays 1.
- exe_branch_taken = 1 and load-use match in the same cycle → pc_en = 1, clr_if_id = 1, clr_id_exe = 1; flush_cnt = 1, stall_cnt unchanged.
- halt_req pulse in RUN → 3 DRAIN cycles with pc_en = 0 and clr_id_exe = 1, then halted = 1; halt_req while HALTED has no effect; resume → pc_en = 1 next cycle, halted = 0.
- Reset asserted in the 2nd DRAIN cycle → INIT next edge; counters 0; full 4-cycle INIT repeats.
- CNT_W = 2, 5 load-use stalls → stall_cnt sequence 1, 2, 3, 3, 3.
